// File: rtl/draw_pkg.sv
// Shared types and constants for the square-drawing queue: FSM states,
// queue entry layout {x[7:0], y[6:0], c[2:0]}, colours and key screen columns.
package draw_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        DRAW = 1'b1
    } state_t;

    localparam int SQ_LOG2_DEFAULT = 3;
    localparam int ENTRY_W         = 18;

    localparam logic [2:0] COLOUR_BLACK = 3'b000;
    localparam logic [2:0] COLOUR_RED   = 3'b100;

    localparam logic [7:0] COL_X0 = 8'd52;
    localparam logic [7:0] COL_X1 = 8'd76;
    localparam logic [7:0] COL_X2 = 8'd100;
    localparam logic [6:0] COL_Y  = 7'd90;

    function automatic logic [ENTRY_W-1:0] pack_entry(input logic [7:0] x,
                                                      input logic [6:0] y,
                                                      input logic [2:0] c);
        return {x, y, c};
    endfunction

endpackage

// File: rtl/sq_fifo.sv
// Circular FIFO of square requests; pushes while full and pops while empty are ignored,
// so a full queue is never overwritten.
module sq_fifo
    import draw_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               push,
    input  logic               pop,
    input  logic [ENTRY_W-1:0] din,
    output logic [ENTRY_W-1:0] dout,
    output logic               full,
    output logic               empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic [ENTRY_W-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]     cnt_q, cnt_d;
    logic               push_ok;
    logic               pop_ok;

    assign full    = (cnt_q == (PTR_W+1)'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign dout    = mem_q[rd_ptr_q];
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    // Depth is a power of two, so the pointers wrap naturally.
    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        cnt_d    = cnt_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (push_ok && !pop_ok) begin
            cnt_d = cnt_q + 1'b1;
        end else if (pop_ok && !push_ok) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/pixel_draw_queue.sv
// Queues square draw requests and rasterises each into 2**SQ_LOG2 x 2**SQ_LOG2 VGA plots.
// Define PIXEL_DRAW_QUEUE_FIFO_EN for a FIFO_DEPTH-entry queue; otherwise a single holding register is used.
module pixel_draw_queue
    import draw_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int SQ_LOG2    = SQ_LOG2_DEFAULT
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [7:0] req_x,
    input  logic [6:0] req_y,
    input  logic [2:0] req_c,
    output logic [7:0] vga_x,
    output logic [6:0] vga_y,
    output logic [2:0] vga_colour,
    output logic       vga_plot,
    output logic       busy
);

    localparam int CNT_W = 2 * SQ_LOG2;

    if (FIFO_DEPTH < 2 || FIFO_DEPTH > 16 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("FIFO_DEPTH must be a power of two between 2 and 16");
    end

    logic               push;
    logic               pop;
    logic               q_full;
    logic               q_empty;
    logic [ENTRY_W-1:0] q_dout;

    assign req_ready = !q_full;
    assign push      = req_valid && !q_full;

`ifdef PIXEL_DRAW_QUEUE_FIFO_EN
    sq_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_sq_fifo (
        .clk    (clk),
        .resetn (resetn),
        .push   (push),
        .pop    (pop),
        .din    (pack_entry(req_x, req_y, req_c)),
        .dout   (q_dout),
        .full   (q_full),
        .empty  (q_empty)
    );
`else
    logic [ENTRY_W-1:0] hold_q, hold_d;
    logic               hold_valid_q, hold_valid_d;

    assign q_full  = hold_valid_q;
    assign q_empty = !hold_valid_q;
    assign q_dout  = hold_q;

    always_comb begin
        hold_d       = hold_q;
        hold_valid_d = hold_valid_q;
        if (pop) begin
            hold_valid_d = 1'b0;
        end
        if (push) begin
            hold_d       = pack_entry(req_x, req_y, req_c);
            hold_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            hold_q       <= '0;
            hold_valid_q <= 1'b0;
        end else begin
            hold_q       <= hold_d;
            hold_valid_q <= hold_valid_d;
        end
    end
`endif

    state_t           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [7:0]       base_x_q, base_x_d;
    logic [6:0]       base_y_q, base_y_d;
    logic [2:0]       base_c_q, base_c_d;

    // count stays at all-ones in IDLE so the VGA outputs keep showing the last pixel.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        base_x_d = base_x_q;
        base_y_d = base_y_q;
        base_c_d = base_c_q;
        pop      = 1'b0;
        case (state_q)
            IDLE: begin
                if (!q_empty) begin
                    pop     = 1'b1;
                    count_d = '0;
                    state_d = DRAW;
                end
            end
            DRAW: begin
                if (&count_q) begin
                    if (!q_empty) begin
                        pop     = 1'b1;
                        count_d = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    count_d = count_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (pop) begin
            base_x_d = q_dout[17:10];
            base_y_d = q_dout[9:3];
            base_c_d = q_dout[2:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q  <= IDLE;
            count_q  <= '0;
            base_x_q <= '0;
            base_y_q <= '0;
            base_c_q <= '0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            base_x_q <= base_x_d;
            base_y_q <= base_y_d;
            base_c_q <= base_c_d;
        end
    end

    assign vga_plot   = (state_q == DRAW);
    assign vga_x      = base_x_q + 8'(count_q[SQ_LOG2-1:0]);
    assign vga_y      = base_y_q + 7'(count_q[CNT_W-1:SQ_LOG2]);
    assign vga_colour = base_c_q;
    assign busy       = (state_q == DRAW) || !q_empty;

endmodule

// File: tb/tb_pixel_draw_queue.sv
// Self-checking bench for pixel_draw_queue: a schedule-based model of square timing
// plus directed scenarios with literal pixel expectations.
module tb_pixel_draw_queue;

    localparam int SIDE   = 8;
    localparam int PIXELS = 64;
`ifdef PIXEL_DRAW_QUEUE_FIFO_EN
    localparam int CAP = 4;
`else
    localparam int CAP = 1;
`endif

    logic       clk;
    logic       resetn;
    logic       req_valid;
    logic       req_ready;
    logic [7:0] req_x;
    logic [6:0] req_y;
    logic [2:0] req_c;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_colour;
    logic       vga_plot;
    logic       busy;

    pixel_draw_queue #(
        .FIFO_DEPTH (4),
        .SQ_LOG2    (3)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_x      (req_x),
        .req_y      (req_y),
        .req_c      (req_c),
        .vga_x      (vga_x),
        .vga_y      (vga_y),
        .vga_colour (vga_colour),
        .vga_plot   (vga_plot),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int pass_cnt  = 0;
    int check_cnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        check_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        check_cnt++;
        $display("[TB] FAIL %s: timed out waiting for the DUT", name);
    endtask

    // Model: each accepted square owns PIXELS consecutive cycles starting at
    // max(accept edge + 1, end of the previous square).
    typedef struct {
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] c;
        int         start;
    } sq_t;

    sq_t         sched[$];
    logic [17:0] obs[$];
    int          n          = 0;
    int          next_free  = 0;
    bit          seen_reset = 0;
    int          cur_run    = 0;
    int          max_run    = 0;
    logic [17:0] last_pix   = '0;
    logic        exp_plot;
    logic        exp_ready;
    logic        exp_busy;
    int          occ;
    int          k;
    int          st;

    always @(negedge clk) begin
        while (sched.size() > 0 && sched[0].start + PIXELS <= n) begin
            void'(sched.pop_front());
        end
        exp_plot = 1'b0;
        occ      = 0;
        foreach (sched[i]) begin
            if (sched[i].start <= n) begin
                k        = n - sched[i].start;
                exp_plot = 1'b1;
                last_pix = {sched[i].x + 8'(k % SIDE), sched[i].y + 7'(k / SIDE), sched[i].c};
            end else begin
                occ++;
            end
        end
        exp_ready = (occ < CAP);
        exp_busy  = exp_plot || (occ > 0);
        if (seen_reset) begin
            check("cycle", {vga_plot, vga_x, vga_y, vga_colour, busy, req_ready},
                  {exp_plot, last_pix, exp_busy, exp_ready});
        end
        if (vga_plot === 1'b1) begin
            obs.push_back({vga_x, vga_y, vga_colour});
            cur_run++;
            if (cur_run > max_run) max_run = cur_run;
        end else begin
            cur_run = 0;
        end
        if (!resetn) begin
            sched.delete();
            last_pix   = '0;
            next_free  = 0;
            seen_reset = 1'b1;
        end else if (req_valid && exp_ready) begin
            st = (n + 2 > next_free) ? n + 2 : next_free;
            sched.push_back('{x: req_x, y: req_y, c: req_c, start: st});
            next_free = st + PIXELS;
        end
        n++;
    end

    task automatic send(input logic [7:0] x, input logic [6:0] y, input logic [2:0] c,
                        output int waited);
        logic rdy;
        bit   accepted;
        accepted  = 1'b0;
        waited    = 0;
        req_x     = x;
        req_y     = y;
        req_c     = c;
        req_valid = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            rdy = req_ready;
            @(posedge clk);
            #1;
            if (rdy === 1'b1) begin
                accepted = 1'b1;
                break;
            end
            waited++;
        end
        req_valid = 1'b0;
        if (!accepted) timeout_fail("send");
    endtask

    task automatic wait_idle(input int limit);
        bit idle;
        idle = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (busy === 1'b0) begin
                idle = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
        if (!idle) timeout_fail("wait_idle");
    endtask

    task automatic clear_obs();
        obs.delete();
        max_run = 0;
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int w;
        int immediate;
        resetn    = 1'b0;
        req_valid = 1'b0;
        req_x     = '0;
        req_y     = '0;
        req_c     = '0;
        repeat (3) @(posedge clk);
        #1;
        resetn = 1'b1;
        @(negedge clk);
        check("reset_plot", 64'(vga_plot), 64'(1'b0));
        check("reset_xyc", {vga_x, vga_y, vga_colour}, 18'h0);
        check("reset_busy", 64'(busy), 64'(1'b0));
        check("reset_ready", 64'(req_ready), 64'(1'b1));
        @(posedge clk);
        #1;

        $display("[TB] single square at (52,90)");
        clear_obs();
        send(8'd52, 7'd90, 3'd4, w);
        @(negedge clk);
        check("latency_idle_cycle", 64'(vga_plot), 64'(1'b0));
        @(negedge clk);
        check("latency_first_plot", {vga_plot, vga_x, vga_y}, {1'b1, 8'd52, 7'd90});
        wait_idle(200);
        check("single_count", obs.size(), 64);
        check("single_first", obs[0], {8'd52, 7'd90, 3'd4});
        check("single_last", obs[63], {8'd59, 7'd97, 3'd4});
        w = 0;
        foreach (obs[i]) if (obs[i][2:0] != 3'd4) w++;
        check("single_colour", w, 0);

        $display("[TB] three back-to-back squares");
        clear_obs();
        send(8'd52, 7'd90, 3'd4, w);
        send(8'd76, 7'd90, 3'd4, w);
        send(8'd100, 7'd90, 3'd0, w);
        wait_idle(400);
        check("b2b_count", obs.size(), 192);
        check("b2b_no_gap", max_run, 192);
        check("b2b_second_first", obs[64], {8'd76, 7'd90, 3'd4});
        check("b2b_third_first", obs[128], {8'd100, 7'd90, 3'd0});
        check("b2b_third_last", obs[191], {8'd107, 7'd97, 3'd0});

        $display("[TB] burst of five while drawing");
        clear_obs();
        send(8'd10, 7'd10, 3'd2, w);
        @(posedge clk);
        #1;
        immediate = 0;
        for (int i = 0; i < 5; i++) begin
            send(8'(20 + 10 * i), 7'(20 + i), 3'(i), w);
            if (w == 0) immediate++;
        end
        wait_idle(600);
        check("burst_immediate_accepts", immediate, CAP);
        check("burst_count", obs.size(), 6 * PIXELS);
        check("burst_no_gap", max_run, 6 * PIXELS);
        check("burst_fifth_first", obs[5 * PIXELS], {8'd60, 7'd24, 3'd4});

        $display("[TB] wrap at (252,126)");
        clear_obs();
        send(8'd252, 7'd126, 3'd1, w);
        wait_idle(200);
        check("wrap_first", obs[0], {8'd252, 7'd126, 3'd1});
        check("wrap_x", obs[4], {8'd0, 7'd126, 3'd1});
        check("wrap_y", obs[16], {8'd252, 7'd0, 3'd1});
        check("wrap_last", obs[63], {8'd3, 7'd5, 3'd1});

        $display("[TB] reset during a square");
        clear_obs();
        send(8'd52, 7'd90, 3'd4, w);
        send(8'd76, 7'd90, 3'd4, w);
        w = 0;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk);
            #1;
            if (obs.size() >= 20) begin
                w = 1;
                break;
            end
        end
        if (w == 0) timeout_fail("reset_wait_count20");
        resetn = 1'b0;
        @(posedge clk);
        #1;
        resetn = 1'b1;
        @(negedge clk);
        check("abort_plot", 64'(vga_plot), 64'(1'b0));
        check("abort_busy", 64'(busy), 64'(1'b0));
        check("abort_ready", 64'(req_ready), 64'(1'b1));
        repeat (150) @(negedge clk);
        check("abort_no_more_pixels", obs.size(), 21);
        @(posedge clk);
        #1;

        $display("[TB] %0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule

// File: doc/pixel_draw_queue.md
PIXEL_DRAW_QUEUE -- requirements
Module: pixel_draw_queue

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, SHALL set the number of buffered square requests (power of two, 2..16).
REQ-002 Parameter SQ_LOG2, default 3, SHALL set the square side as 2**SQ_LOG2 pixels (8x8, 64 pixels).
REQ-003 Port clk, input, 1, SHALL be the clock; all state updates on its rising edge.
REQ-004 Port resetn, input, 1, SHALL be the synchronous, active-low reset.
REQ-005 Port req_valid, input, 1, SHALL mean a square draw request is presented.
REQ-006 Port req_ready, output, 1, SHALL mean the block accepts the request this cycle.
REQ-007 Port req_x, input, 8, SHALL be the square's top-left x.
REQ-008 Port req_y, input, 7, SHALL be the square's top-left y.
REQ-009 Port req_c, input, 3, SHALL be the square's colour.
REQ-010 Port vga_x, output, 8, SHALL be the pixel x sent to the VGA adapter.
REQ-011 Port vga_y, output, 7, SHALL be the pixel y sent to the VGA adapter.
REQ-012 Port vga_colour, output, 3, SHALL be the pixel colour.
REQ-013 Port vga_plot, output, 1, SHALL be the VGA write enable, one pixel per high cycle.
REQ-014 Port busy, output, 1, SHALL be high when state is DRAW or the queue is non-empty.

Function
REQ-015 A request SHALL be accepted only on an edge where req_valid and req_ready are both high; req_ready SHALL equal not-full, independent of req_valid and of any same-cycle pop.
REQ-016 States SHALL be IDLE and DRAW; IDLE with queue non-empty SHALL pop the head into base_x/base_y/base_c, clear count, and enter DRAW.
REQ-017 In DRAW, vga_plot SHALL be 1; vga_x = base_x + count[SQ_LOG2-1:0] modulo 256; vga_y = base_y + count[2*SQ_LOG2-1:SQ_LOG2] modulo 128; vga_colour = base_c.
REQ-018 count SHALL increment by 1 per DRAW cycle, raster order (x fastest).
REQ-019 On the last pixel (count all-ones), a non-empty queue SHALL be popped directly into DRAW with count 0 (no bubble); an empty queue SHALL return to IDLE.
REQ-020 Latency: a request accepted at edge E into an empty, idle block SHALL produce its first vga_plot=1 in the cycle after edge E+1.
REQ-021 In IDLE, vga_plot SHALL be 0, and vga_x/vga_y/vga_colour SHALL hold their last values.
REQ-022 A request pushed on the same edge as a pop SHALL be stored; a full queue SHALL never be overwritten.
REQ-023 Outputs SHALL depend only on registered state (no combinational path from req_* to vga_*).

Reset
REQ-024 On resetn low at an edge, the queue SHALL empty, state SHALL go to IDLE, and count, base_x, base_y and base_c SHALL clear to 0.
REQ-025 After reset, outputs SHALL be vga_plot=0, vga_x=0, vga_y=0, vga_colour=0, busy=0 and req_ready=1.
REQ-026 Reset during DRAW SHALL abort the square immediately; no further pixels SHALL be plotted.

Configuration
REQ-027 Macro PIXEL_DRAW_QUEUE_FIFO_EN defined: the FIFO_DEPTH-entry queue SHALL be used.
REQ-028 Macro undefined: a single holding register SHALL replace the queue; req_ready SHALL be 1 only when the register is empty; all other behaviour SHALL be unchanged.

Structure
REQ-029 Package draw_pkg SHALL hold the state enumeration, SQ_LOG2 default, colour constants (black 3'b000, red 3'b100), and key column constants (x 52/76/100, y 90).
REQ-030 The queue SHALL be a sub-module sq_fifo (parameterised depth, 18-bit entry {x,y,c}, push/pop/full/empty).

Verification
REQ-031 Single request (52,90,4): exactly 64 plot cycles; the first pixel is (52,90), the last is (59,97), and colour is 4 throughout.
REQ-032 Three back-to-back requests (52,90,4), (76,90,4), (100,90,0): 192 consecutive plot cycles with no gap between squares.
REQ-033 Five requests pushed while the first square is drawing (FIFO_EN, depth 4): req_ready drops when full; the fifth is accepted only after the first pop; no entry is lost.
REQ-034 Wrap case (252,126,1): the first pixel is (252,126); pixel 4 wraps to x=0; row 2 wraps to y=0.
REQ-035 Reset asserted at count 20 of a square: the next cycle shows plot=0, busy=0, ready=1; a queued request is discarded.
REQ-036 Without FIFO_EN: a second request is held off (ready=0) until the holding register is popped, then drawn directly after the first square.
